// File: rtl/pmem_arb_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
// Grant selection lives here so the tie-break rule sits in one place.
package pmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

    // Only meaningful when at least one request is present.
    function automatic requester_t pick_grant(
        input logic       i_req,
        input logic       d_req,
        input requester_t last,
        input logic       rr_en
    );
        requester_t g;
        g = ICACHE;
        if (i_req && d_req) begin
            if (rr_en) begin
                g = (last == ICACHE) ? DCACHE : ICACHE;
            end else begin
                g = DCACHE;
            end
        end else if (d_req) begin
            g = DCACHE;
        end
        return g;
    endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Merges I-cache and D-cache line traffic onto one physical-memory port.
// One transaction at a time; one idle RECOVER cycle after every completion.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state;
    requester_t last_grant;
    requester_t grant;

    logic i_req;
    logic d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        grant = pick_grant(i_req, d_req, last_grant, RR_EN);
    end

    // Response steering is combinational so the owner sees the pulse with the data.
    assign i_pmem_resp  = (state == SERVE_I) & mem_resp;
    assign d_pmem_resp  = (state == SERVE_D) & mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= ICACHE;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (grant == DCACHE) begin
                            // A writeback beats a read if both are raised.
                            state       <= SERVE_D;
                            mem_address <= d_pmem_address;
                            mem_read    <= ~d_pmem_write;
                            mem_write   <= d_pmem_write;
                            mem_wdata   <= d_pmem_write ? d_pmem_wdata : '0;
                        end else begin
                            state       <= SERVE_I;
                            mem_address <= i_pmem_address;
                            mem_read    <= 1'b1;
                            mem_write   <= 1'b0;
                            mem_wdata   <= '0;
                        end
                    end
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        state       <= RECOVER;
                        last_grant  <= ICACHE;
                        mem_address <= '0;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_wdata   <= '0;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        state       <= RECOVER;
                        last_grant  <= DCACHE;
                        mem_address <= '0;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_wdata   <= '0;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rw_conflict: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(d_pmem_read && d_pmem_write)
    ) else $warning("pmem_arbiter: d read and write together, write taken");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter with a fixed-latency memory model.
// Expected issues and responses are queued by stimulus and popped by monitors.
module tb_pmem_arbiter;
    import pmem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int LAT = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [LW-1:0] wdata;
    } issue_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic          i_pmem_read = 1'b0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic [AW-1:0] d_pmem_address = '0;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int tests = 0;
    int fails = 0;
    logic [LW-1:0] i_exp[$];
    logic [LW-1:0] d_exp[$];
    issue_t        iss_exp[$];
    logic [LW-1:0] memory[logic [AW-1:0]];
    int            lat_cnt = 0;
    logic          spur = 1'b0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Memory: answers LAT cycles after a command appears; writes echo wdata.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_resp = 1'b0;
            lat_cnt  = 0;
        end else if (mem_resp) begin
            mem_resp = 1'b0;
            lat_cnt  = 0;
        end else if (spur) begin
            mem_resp  = 1'b1;
            mem_rdata = {8{32'h5151_5151}};
            spur      = 1'b0;
        end else if (mem_read || mem_write) begin
            lat_cnt++;
            if (lat_cnt == LAT) begin
                mem_resp = 1'b1;
                if (mem_write) begin
                    memory[mem_address] = mem_wdata;
                    mem_rdata = mem_wdata;
                end else if (memory.exists(mem_address)) begin
                    mem_rdata = memory[mem_address];
                end else begin
                    mem_rdata = '0;
                end
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Response monitor.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (i_pmem_resp && d_pmem_resp) note_fail("both_resp");
            if (i_pmem_resp) begin
                if (i_exp.size() == 0) note_fail("i_resp_unexpected");
                else chk("i_rdata", 512'(i_pmem_rdata), 512'(i_exp.pop_front()));
            end
            if (d_pmem_resp) begin
                if (d_exp.size() == 0) note_fail("d_resp_unexpected");
                else chk("d_rdata", 512'(d_pmem_rdata), 512'(d_exp.pop_front()));
            end
        end
    end

    // Issue monitor: new commands against the queue, held commands for stability.
    initial begin
        logic   prev_act;
        logic   act;
        issue_t cur;
        issue_t e;
        prev_act = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            act = mem_read | mem_write;
            if (act && !prev_act) begin
                if (iss_exp.size() == 0) begin
                    note_fail("issue_unexpected");
                end else begin
                    e = iss_exp.pop_front();
                    chk("issue_addr", 512'(mem_address), 512'(e.addr));
                    chk("issue_rd", 512'(mem_read), 512'(e.rd));
                    chk("issue_wr", 512'(mem_write), 512'(e.wr));
                    chk("issue_wdata", 512'(mem_wdata), 512'(e.wdata));
                end
                cur = {mem_address, mem_read, mem_write, mem_wdata};
            end else if (act && prev_act) begin
                chk("mem_stable",
                    512'({mem_address, mem_read, mem_write, mem_wdata}),
                    512'(cur));
            end
            prev_act = act;
        end
    end

    task automatic wait_i();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_pmem_resp && n < 60);
        if (!i_pmem_resp) note_fail("i_timeout");
    endtask

    task automatic wait_d();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_pmem_resp && n < 60);
        if (!d_pmem_resp) note_fail("d_timeout");
    endtask

    task automatic run_i(input logic [AW-1:0] a);
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        wait_i();
        i_pmem_read    = 1'b0;
    endtask

    task automatic run_d(input logic [AW-1:0] a, input logic rd,
                         input logic wr, input logic [LW-1:0] wd);
        d_pmem_address = a;
        d_pmem_read    = rd;
        d_pmem_write   = wr;
        d_pmem_wdata   = wd;
        wait_d();
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int n;
        logic [LW-1:0] w;

        memory[32'h0000_1240] = {32{8'hA5}};
        memory[32'h0000_0100] = {8{32'h1111_0100}};
        memory[32'h0000_0200] = {8{32'h2222_0200}};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", 512'(mem_read), 512'(0));
        chk("rst_mem_write", 512'(mem_write), 512'(0));
        chk("rst_mem_address", 512'(mem_address), 512'(0));
        chk("rst_mem_wdata", 512'(mem_wdata), 512'(0));
        chk("rst_i_resp", 512'(i_pmem_resp), 512'(0));
        chk("rst_d_resp", 512'(d_pmem_resp), 512'(0));
        chk("rst_state", 512'(dut.state), 512'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Async reset in the middle of a D writeback
        w = {8{32'h0BAD_F00D}};
        @(posedge clk);
        #1;
        iss_exp.push_back('{addr: 32'h0800, rd: 1'b0, wr: 1'b1, wdata: w});
        d_pmem_address = 32'h0800;
        d_pmem_wdata   = w;
        d_pmem_write   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_write && n < 5);
        chk("t1_write_seen", 512'(mem_write), 512'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_write", 512'(mem_write), 512'(0));
        chk("t1_async_state", 512'(dut.state), 512'(IDLE));
        d_pmem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // I-only read with exact cycle timing
        @(posedge clk);
        #1;
        iss_exp.push_back('{addr: 32'h1240, rd: 1'b1, wr: 1'b0, wdata: '0});
        i_exp.push_back({32{8'hA5}});
        i_pmem_address = 32'h0000_1240;
        i_pmem_read    = 1'b1;
        @(negedge clk);
        chk("t2_c0_read", 512'(mem_read), 512'(0));
        @(negedge clk);
        chk("t2_c1_read", 512'(mem_read), 512'(1));
        chk("t2_c1_addr", 512'(mem_address), 512'(32'h1240));
        repeat (2) begin
            @(negedge clk);
            chk("t2_early_resp", 512'(i_pmem_resp), 512'(0));
        end
        @(negedge clk);
        chk("t2_c4_iresp", 512'(i_pmem_resp), 512'(1));
        chk("t2_c4_dresp", 512'(d_pmem_resp), 512'(0));
        i_pmem_read = 1'b0;
        @(negedge clk);
        chk("t2_c5_read", 512'(mem_read), 512'(0));

        // Tie after reset: D first, then I
        do_reset();
        @(posedge clk);
        #1;
        iss_exp.push_back('{addr: 32'h0200, rd: 1'b1, wr: 1'b0, wdata: '0});
        iss_exp.push_back('{addr: 32'h0100, rd: 1'b1, wr: 1'b0, wdata: '0});
        d_exp.push_back({8{32'h2222_0200}});
        i_exp.push_back({8{32'h1111_0100}});
        fork
            run_i(32'h0100);
            run_d(32'h0200, 1'b1, 1'b0, '0);
        join

        // D writeback
        w = {8{32'hDEAD_BEEF}};
        @(posedge clk);
        #1;
        iss_exp.push_back('{addr: 32'h3FE0, rd: 1'b0, wr: 1'b1, wdata: w});
        d_exp.push_back(w);
        run_d(32'h3FE0, 1'b0, 1'b1, w);

        // Stale level request held through RECOVER
        @(posedge clk);
        #1;
        iss_exp.push_back('{addr: 32'h0100, rd: 1'b1, wr: 1'b0, wdata: '0});
        iss_exp.push_back('{addr: 32'h0100, rd: 1'b1, wr: 1'b0, wdata: '0});
        i_exp.push_back({8{32'h1111_0100}});
        i_exp.push_back({8{32'h1111_0100}});
        i_pmem_address = 32'h0100;
        i_pmem_read    = 1'b1;
        wait_i();
        @(negedge clk);
        chk("t5_recover_read", 512'(mem_read), 512'(0));
        chk("t5_recover_state", 512'(dut.state), 512'(RECOVER));
        @(negedge clk);
        chk("t5_idle_read", 512'(mem_read), 512'(0));
        chk("t5_idle_state", 512'(dut.state), 512'(IDLE));
        @(negedge clk);
        chk("t5_regrant", 512'(mem_read), 512'(1));
        wait_i();
        i_pmem_read = 1'b0;

        // Spurious mem_resp while idle
        repeat (3) @(negedge clk);
        spur = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (i_pmem_resp || d_pmem_resp) pulses++;
        end
        chk("t6_spur_no_resp", 512'(pulses), 512'(0));

        // D read and write together: write issued
        w = {8{32'hCAFE_0400}};
        @(posedge clk);
        #1;
        iss_exp.push_back('{addr: 32'h0400, rd: 1'b0, wr: 1'b1, wdata: w});
        d_exp.push_back(w);
        run_d(32'h0400, 1'b1, 1'b1, w);

        repeat (4) @(negedge clk);
        chk("end_i_queue", 512'(i_exp.size()), 512'(0));
        chk("end_d_queue", 512'(d_exp.size()), 512'(0));
        chk("end_issue_queue", 512'(iss_exp.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
